// File: rtl/lc3_wb_pkg.sv
// Shared types and helpers for the parametrised LC3 writeback stage.
//   wb_sel_e : writeback source select encoding (W_control_in)
//   PSR_*    : one-hot NZP flag values, {N,Z,P}
//   nzp()    : flag encoder; the caller passes the sign bit and a zero test,
//              so the function works for any data width.
package lc3_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_NPC = 2'd3
  } wb_sel_e;

  localparam logic [2:0] PSR_N = 3'b100;
  localparam logic [2:0] PSR_Z = 3'b010;
  localparam logic [2:0] PSR_P = 3'b001;

  function automatic logic [2:0] nzp(input logic neg, input logic zero);
    if (neg)       return PSR_N;
    else if (zero) return PSR_Z;
    else           return PSR_P;
  endfunction

endpackage

// File: rtl/lc3_regfile_2r1w.sv
// Register file, two read ports / one write port.
//   clock, reset : rising-edge clock, async active-high reset (clears storage
//                  and the registered read copies)
//   we, wa, wd   : write strobe (already range-qualified by the caller),
//                  index, data
//   ra[1:0]      : read indices; indices >= NUM_REGS read as zero
//   rd[1:0]      : read data, combinational (RD_REG=0) or registered (RD_REG=1)
// With BYPASS=1 a matching write is forwarded into the lookup, so a
// combinational port shows the new value in the write cycle and a registered
// port captures the post-write value.
module lc3_regfile_2r1w
  import lc3_wb_pkg::*;
#(
  parameter  int NUM_REGS = 8,
  parameter  int DATA_W   = 16,
  parameter  int BYPASS   = 1,
  parameter  int RD_REG   = 0,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        we,
  input  logic [REG_AW-1:0]           wa,
  input  logic [DATA_W-1:0]           wd,
  input  logic [1:0][REG_AW-1:0]      ra,
  output logic [1:0][DATA_W-1:0]      rd
);

  logic [NUM_REGS-1:0][DATA_W-1:0] rf;
  logic [1:0][DATA_W-1:0]          lookup;

  // Index-compare loop rather than rf[wa] so a non power-of-2 NUM_REGS never
  // addresses a nonexistent entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rf <= '0;
    else if (we)
      for (int i = 0; i < NUM_REGS; i++)
        if (wa == REG_AW'(i)) rf[i] <= wd;
  end

  // Unmatched (out-of-range) indices fall through to the zero default.
  always_comb begin
    lookup = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (ra[p] == REG_AW'(i)) lookup[p] = rf[i];
      if (BYPASS != 0 && we && wa == ra[p]) lookup[p] = wd;
    end
  end

  if (RD_REG != 0) begin : g_rd_reg
    always_ff @(posedge clock or posedge reset) begin
      if (reset) rd <= '0;
      else       rd <= lookup;
    end
  end else begin : g_rd_comb
    assign rd = lookup;
  end

endmodule

// File: rtl/lc3_writeback_param.sv
// Parametrised LC3 writeback stage.
//   clock, reset          : rising-edge clock, async active-high reset
//   enable_writeback      : write strobe for this cycle
//   W_control_in          : source select (0 alu, 1 mem, 2 pc, 3 npc)
//   aluout/memout/pcout/npc : candidate writeback data
//   dr                    : destination index; dr >= NUM_REGS drops the write
//   sr1, sr2 / d1, d2     : read ports
//   psr                   : {N,Z,P} of the last committed write
//   wb_commit, illegal_dr : one-cycle registered pulses per strobe outcome
//   commit_count          : saturating count of committed writes
module lc3_writeback_param
  import lc3_wb_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 8,
  parameter  int BYPASS   = 1,
  parameter  int RD_REG   = 0,
  parameter  int CNT_W    = 16,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [DATA_W-1:0] npc,
  input  logic [1:0]        W_control_in,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] memout,
  input  logic [REG_AW-1:0] sr1,
  input  logic [REG_AW-1:0] sr2,
  input  logic [REG_AW-1:0] dr,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic [2:0]        psr,
  output logic              wb_commit,
  output logic              illegal_dr,
  output logic [CNT_W-1:0]  commit_count
);

  // One extra bit so NUM_REGS == 2**REG_AW is representable.
  localparam logic [REG_AW:0] REGS_LIM = (REG_AW+1)'(NUM_REGS);

  wb_sel_e                sel;
  logic [DATA_W-1:0]      wb_data;
  logic                   dr_ok, wr_en;
  logic [1:0][DATA_W-1:0] rd_data;

  assign sel   = wb_sel_e'(W_control_in);
  assign dr_ok = {1'b0, dr} < REGS_LIM;
  assign wr_en = enable_writeback & dr_ok;

  always_comb begin
    wb_data = aluout;
    unique case (sel)
      WB_ALU: wb_data = aluout;
      WB_MEM: wb_data = memout;
      WB_PC:  wb_data = pcout;
      WB_NPC: wb_data = npc;
    endcase
  end

  lc3_regfile_2r1w #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .BYPASS   (BYPASS),
    .RD_REG   (RD_REG)
  ) u_rf (
    .clock (clock),
    .reset (reset),
    .we    (wr_en),
    .wa    (dr),
    .wd    (wb_data),
    .ra    ({sr2, sr1}),
    .rd    (rd_data)
  );

  assign d1 = rd_data[0];
  assign d2 = rd_data[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      psr          <= PSR_Z;
      wb_commit    <= 1'b0;
      illegal_dr   <= 1'b0;
      commit_count <= '0;
    end else begin
      wb_commit  <= wr_en;
      illegal_dr <= enable_writeback & ~dr_ok;
      if (wr_en) begin
        psr <= nzp(wb_data[DATA_W-1], ~|wb_data);
        if (commit_count != '1) commit_count <= commit_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lc3_writeback_param.sv
// Bench for lc3_writeback_param: three configurations share one stimulus
// stream; a per-configuration reference model predicts every output.
//   dut0: 8 regs, bypass, combinational reads, 16-bit count
//   dut1: 6 regs, no bypass, combinational reads, 3-bit count
//   dut2: 8 regs, bypass, registered reads, 16-bit count
module tb_lc3_writeback_param;

  logic        clock = 1'b0, reset = 1'b1, en = 1'b0;
  logic [1:0]  sel = '0;
  logic [15:0] npc = '0, alu = '0, pco = '0, mem = '0;
  logic [2:0]  sr1 = '0, sr2 = '0, dr = '0;

  always #5 clock = ~clock;

  logic [15:0] d1_o [3], d2_o [3], cnt_o [3];
  logic [2:0]  psr_o [3];
  logic        com_o [3], ill_o [3];
  logic [2:0]  cnt1;
  assign cnt_o[1] = {13'b0, cnt1};

  lc3_writeback_param #(.DATA_W(16), .NUM_REGS(8), .BYPASS(1), .RD_REG(0), .CNT_W(16)) dut0 (
    .clock(clock), .reset(reset), .enable_writeback(en), .npc(npc), .W_control_in(sel),
    .aluout(alu), .pcout(pco), .memout(mem), .sr1(sr1), .sr2(sr2), .dr(dr),
    .d1(d1_o[0]), .d2(d2_o[0]), .psr(psr_o[0]), .wb_commit(com_o[0]), .illegal_dr(ill_o[0]),
    .commit_count(cnt_o[0]));

  lc3_writeback_param #(.DATA_W(16), .NUM_REGS(6), .BYPASS(0), .RD_REG(0), .CNT_W(3)) dut1 (
    .clock(clock), .reset(reset), .enable_writeback(en), .npc(npc), .W_control_in(sel),
    .aluout(alu), .pcout(pco), .memout(mem), .sr1(sr1), .sr2(sr2), .dr(dr),
    .d1(d1_o[1]), .d2(d2_o[1]), .psr(psr_o[1]), .wb_commit(com_o[1]), .illegal_dr(ill_o[1]),
    .commit_count(cnt1));

  lc3_writeback_param #(.DATA_W(16), .NUM_REGS(8), .BYPASS(1), .RD_REG(1), .CNT_W(16)) dut2 (
    .clock(clock), .reset(reset), .enable_writeback(en), .npc(npc), .W_control_in(sel),
    .aluout(alu), .pcout(pco), .memout(mem), .sr1(sr1), .sr2(sr2), .dr(dr),
    .d1(d1_o[2]), .d2(d2_o[2]), .psr(psr_o[2]), .wb_commit(com_o[2]), .illegal_dr(ill_o[2]),
    .commit_count(cnt_o[2]));

  typedef struct {
    int          k;
    string       tag;
    logic [15:0] d1, d2, cnt;
    logic [2:0]  psr;
    logic        c, i;
  } snap_t;

  snap_t exp_q[$], obs_q[$];
  int    n_cmp = 0, n_bad = 0;
  string cur_tag = "none";

  // Reference model
  int          nregs [3] = '{8, 6, 8};
  bit          byp   [3] = '{1'b1, 1'b0, 1'b1};
  bit          rdreg [3] = '{1'b0, 1'b0, 1'b1};
  logic [15:0] cmax  [3] = '{16'hFFFF, 16'd7, 16'hFFFF};
  logic [15:0] m_rf  [3][8];
  logic [2:0]  m_psr [3];
  logic        m_c [3], m_i [3];
  logic [15:0] m_cnt [3], m_d1 [3], m_d2 [3];

  function automatic logic [15:0] wb_val();
    case (sel)
      2'd0:    return alu;
      2'd1:    return mem;
      2'd2:    return pco;
      default: return npc;
    endcase
  endfunction

  function automatic logic [15:0] m_read(int k, logic [2:0] s);
    if (int'(s) >= nregs[k]) return 16'h0;
    if (byp[k] && en && int'(dr) < nregs[k] && dr == s) return wb_val();
    return m_rf[k][s];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 8; r++) m_rf[k][r] = '0;
      m_psr[k] = 3'b010; m_c[k] = 0; m_i[k] = 0; m_cnt[k] = '0; m_d1[k] = '0; m_d2[k] = '0;
    end
  endtask

  task automatic model_edge();
    logic [15:0] w, n1, n2;
    w = wb_val();
    for (int k = 0; k < 3; k++) begin
      n1 = m_read(k, sr1);
      n2 = m_read(k, sr2);
      if (en && int'(dr) < nregs[k]) begin
        m_rf[k][dr] = w;
        m_psr[k] = w[15] ? 3'b100 : (w == 16'h0) ? 3'b010 : 3'b001;
        m_c[k] = 1; m_i[k] = 0;
        if (m_cnt[k] != cmax[k]) m_cnt[k] = m_cnt[k] + 16'd1;
      end else begin
        m_c[k] = 0; m_i[k] = en;
      end
      m_d1[k] = n1; m_d2[k] = n2;
    end
  endtask

  // Drive one cycle: inputs at negedge, expectations queued, outputs
  // snapshotted just before the next rising edge, then the model steps.
  task automatic cycle(input bit e, input logic [1:0] s, input logic [2:0] d,
                       input logic [2:0] a, input logic [2:0] b, input logic [15:0] v);
    snap_t x;
    @(negedge clock);
    en = e; sel = s; dr = d; sr1 = a; sr2 = b;
    alu = 16'($urandom); mem = 16'($urandom); pco = 16'($urandom); npc = 16'($urandom);
    case (s)
      2'd0:    alu = v;
      2'd1:    mem = v;
      2'd2:    pco = v;
      default: npc = v;
    endcase
    for (int k = 0; k < 3; k++) begin
      x.k = k; x.tag = cur_tag;
      x.d1 = rdreg[k] ? m_d1[k] : m_read(k, sr1);
      x.d2 = rdreg[k] ? m_d2[k] : m_read(k, sr2);
      x.psr = m_psr[k]; x.c = m_c[k]; x.i = m_i[k]; x.cnt = m_cnt[k];
      exp_q.push_back(x);
    end
    #4;
    for (int k = 0; k < 3; k++) begin
      x.k = k; x.tag = cur_tag;
      x.d1 = d1_o[k]; x.d2 = d2_o[k]; x.psr = psr_o[k];
      x.c = com_o[k]; x.i = ill_o[k]; x.cnt = cnt_o[k];
      obs_q.push_back(x);
    end
    @(posedge clock);
    model_edge();
  endtask

  task automatic test_reset();
    snap_t e, o;
    cur_tag = "reset_idle";
    reset = 1; model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 0;
    cycle(0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    cycle(0, 2'd0, 3'd0, 3'd3, 3'd5, 16'h0);
    cur_tag = "reset_prewrite";
    cycle(1, 2'd0, 3'd3, 3'd3, 3'd3, 16'h8001);
    // Reset asserted between edges while a write is being presented.
    @(negedge clock);
    en = 1; sel = 2'd0; dr = 3'd3; alu = 16'h1234;
    #2 reset = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (psr_o[k] !== 3'b010 || cnt_o[k] !== 16'h0 || com_o[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL async_reset dut%0d: got psr=%b cnt=%0d commit=%b, want psr=010 cnt=0 commit=0",
                 k, psr_o[k], cnt_o[k], com_o[k]);
      end
    end
    @(posedge clock);
    @(negedge clock); en = 0; reset = 0; model_reset();
    cur_tag = "reset_rf3_zero";
    cycle(0, 2'd0, 3'd0, 3'd3, 3'd3, 16'h0);
    cycle(0, 2'd0, 3'd0, 3'd3, 3'd3, 16'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.d1 !== e.d1 || o.d2 !== e.d2 || o.psr !== e.psr || o.c !== e.c || o.i !== e.i || o.cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s dut%0d: got d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d, want d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d",
                 e.tag, e.k, o.d1, o.d2, o.psr, o.c, o.i, o.cnt, e.d1, e.d2, e.psr, e.c, e.i, e.cnt);
      end
    end
  endtask

  task automatic test_sources();
    snap_t e, o;
    cur_tag = "src_alu_neg";
    cycle(1, 2'd0, 3'd2, 3'd0, 3'd0, 16'h8001);
    cycle(0, 2'd0, 3'd0, 3'd2, 3'd2, 16'h0);
    cur_tag = "src_mem_zero";
    cycle(1, 2'd1, 3'd4, 3'd4, 3'd2, 16'h0);
    cur_tag = "src_npc_pos";
    cycle(1, 2'd3, 3'd1, 3'd1, 3'd4, 16'h3001);
    cur_tag = "psr_hold";
    repeat (4) cycle(0, 2'd2, 3'd0, 3'd1, 3'd2, 16'hFFFF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.d1 !== e.d1 || o.d2 !== e.d2 || o.psr !== e.psr || o.c !== e.c || o.i !== e.i || o.cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s dut%0d: got d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d, want d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d",
                 e.tag, e.k, o.d1, o.d2, o.psr, o.c, o.i, o.cnt, e.d1, e.d2, e.psr, e.c, e.i, e.cnt);
      end
    end
  endtask

  task automatic test_bypass();
    snap_t e, o;
    cur_tag = "bypass_same_cycle";
    cycle(1, 2'd2, 3'd5, 3'd5, 3'd5, 16'h00AA);
    cur_tag = "bypass_after";
    cycle(0, 2'd0, 3'd0, 3'd5, 3'd5, 16'h0);
    cycle(0, 2'd0, 3'd0, 3'd5, 3'd5, 16'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.d1 !== e.d1 || o.d2 !== e.d2 || o.psr !== e.psr || o.c !== e.c || o.i !== e.i || o.cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s dut%0d: got d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d, want d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d",
                 e.tag, e.k, o.d1, o.d2, o.psr, o.c, o.i, o.cnt, e.d1, e.d2, e.psr, e.c, e.i, e.cnt);
      end
    end
  endtask

  task automatic test_rdreg();
    snap_t e, o;
    cur_tag = "rdreg_write";
    cycle(1, 2'd0, 3'd1, 3'd0, 3'd0, 16'h0F0F);
    cur_tag = "rdreg_read";
    cycle(0, 2'd0, 3'd0, 3'd0, 3'd1, 16'h0);
    cycle(0, 2'd0, 3'd0, 3'd0, 3'd1, 16'h0);
    cycle(0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.d1 !== e.d1 || o.d2 !== e.d2 || o.psr !== e.psr || o.c !== e.c || o.i !== e.i || o.cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s dut%0d: got d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d, want d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d",
                 e.tag, e.k, o.d1, o.d2, o.psr, o.c, o.i, o.cnt, e.d1, e.d2, e.psr, e.c, e.i, e.cnt);
      end
    end
  endtask

  task automatic test_illegal();
    snap_t e, o;
    cur_tag = "illegal_dr7";
    cycle(1, 2'd0, 3'd7, 3'd6, 3'd7, 16'h1357);
    cur_tag = "illegal_after";
    cycle(0, 2'd0, 3'd0, 3'd6, 3'd7, 16'h0);
    cycle(1, 2'd1, 3'd6, 3'd6, 3'd7, 16'h8000);
    cycle(0, 2'd0, 3'd0, 3'd6, 3'd7, 16'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.d1 !== e.d1 || o.d2 !== e.d2 || o.psr !== e.psr || o.c !== e.c || o.i !== e.i || o.cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s dut%0d: got d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d, want d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d",
                 e.tag, e.k, o.d1, o.d2, o.psr, o.c, o.i, o.cnt, e.d1, e.d2, e.psr, e.c, e.i, e.cnt);
      end
    end
  endtask

  task automatic test_saturate();
    snap_t e, o;
    @(negedge clock); en = 0; reset = 1; model_reset();
    @(negedge clock); reset = 0;
    cur_tag = "saturate";
    for (int n = 0; n < 9; n++)
      cycle(1, 2'(n), 3'(n % 6), 3'(n % 6), 3'((n + 1) % 6), 16'(n + 1));
    #1;
    n_cmp++;
    if (cnt_o[1] !== 16'd7) begin
      n_bad++;
      $display("FAIL sat_count_3bit: got %0d, want 7", cnt_o[1]);
    end
    cur_tag = "saturate_hold";
    cycle(1, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0042);
    cycle(0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.d1 !== e.d1 || o.d2 !== e.d2 || o.psr !== e.psr || o.c !== e.c || o.i !== e.i || o.cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s dut%0d: got d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d, want d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d",
                 e.tag, e.k, o.d1, o.d2, o.psr, o.c, o.i, o.cnt, e.d1, e.d2, e.psr, e.c, e.i, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    snap_t e, o;
    cur_tag = "random_b2b";
    for (int n = 0; n < 40; n++)
      cycle(1'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
            (n % 5 == 0) ? 16'h0 : 16'($urandom));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.d1 !== e.d1 || o.d2 !== e.d2 || o.psr !== e.psr || o.c !== e.c || o.i !== e.i || o.cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s dut%0d: got d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d, want d1=%h d2=%h psr=%b c=%b i=%b cnt=%0d",
                 e.tag, e.k, o.d1, o.d2, o.psr, o.c, o.i, o.cnt, e.d1, e.d2, e.psr, e.c, e.i, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sources();
    test_bypass();
    test_rdreg();
    test_illegal();
    test_saturate();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
